// File: rtl/cpu7_csr_tmr_pkg.sv
// cpu7_csr_tmr_pkg: CSR addresses, field positions and exception codes shared by the CSR file and its bench
package cpu7_csr_tmr_pkg;
  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00c;
  localparam logic [13:0] CSR_SAVE_BASE = 14'h030;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam int CRMD_IE        = 2;
  localparam int CRMD_PLV       = 0;
  localparam int ESTAT_IS       = 0;
  localparam int ESTAT_TI       = 11;
  localparam int ESTAT_ECODE    = 16;
  localparam int ESTAT_ESUBCODE = 22;
  localparam int TCFG_EN        = 0;
  localparam int TCFG_PERIODIC  = 1;
  localparam int TICLR_CLR      = 0;
  localparam logic [12:0] LIE_MASK = 13'h1bff;
  typedef enum logic [5:0] {
    ECODE_INT = 6'h00,
    ECODE_PIL = 6'h01,
    ECODE_PIS = 6'h02,
    ECODE_PIF = 6'h03,
    ECODE_PME = 6'h04,
    ECODE_PPI = 6'h07,
    ECODE_ADE = 6'h08,
    ECODE_ALE = 6'h09,
    ECODE_SYS = 6'h0b,
    ECODE_BRK = 6'h0c,
    ECODE_INE = 6'h0d,
    ECODE_IPE = 6'h0e,
    ECODE_FPD = 6'h0f
  } ecode_e;
endpackage

// File: rtl/cpu7_csr_timer.sv
// cpu7_csr_timer: TVAL down-counter with one-shot/periodic reload and the timer pending bit
module cpu7_csr_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic [TIMER_W-1:0] reload_i,
  input  logic               en_i,
  input  logic               periodic_i,
  input  logic               clr_i,
  output logic [TIMER_W-1:0] tval_o,
  output logic               pend_o
);
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic pend_q, pend_d, expire;
  // a TCFG write reloads outright; expiry beats a same-cycle clear of the pending bit
  always_comb begin
    expire = !load_i && en_i && tval_q == TIMER_W'(1);
    tval_d = load_i ? load_val_i : expire ? (periodic_i ? reload_i : '0) :
             (en_i && tval_q != '0) ? tval_q - TIMER_W'(1) : tval_q;
    pend_d = expire || (pend_q && !clr_i);
  end
  // counter and pending state
  always_ff @(posedge clk) begin
    if (rst) begin
      tval_q <= '0;
      pend_q <= 1'b0;
    end else begin
      tval_q <= tval_d;
      pend_q <= pend_d;
    end
  end
  assign tval_o = tval_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/cpu7_csr_tmr.sv
// cpu7_csr_tmr: cpu7 CSR file with exception bookkeeping, SAVE scratch registers and stable-counter timer
module cpu7_csr_tmr import cpu7_csr_tmr_pkg::*; #(
  parameter int GRLEN    = 32,
  parameter int CSR_BIT  = 14,
  parameter int NUM_SAVE = 4,
  parameter int TIMER_W  = 32,
  parameter int HWI_N    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CSR_BIT-1:0] csr_raddr,
  output logic [GRLEN-1:0]   csr_rdata,
  input  logic [CSR_BIT-1:0] csr_waddr,
  input  logic [GRLEN-1:0]   csr_wdata,
  input  logic [GRLEN-1:0]   csr_mask,
  input  logic               csr_wen,
  input  logic               excp_e,
  input  logic [5:0]         excp_ecode_e,
  input  logic [8:0]         excp_esubcode_e,
  input  logic               excp_badv_vld_e,
  input  logic [GRLEN-1:0]   excp_badv_e,
  input  logic [GRLEN-1:0]   pc_e,
  input  logic               ertn_e,
  input  logic [HWI_N-1:0]   hwi,
  output logic [GRLEN-1:0]   csr_eentry,
  output logic [GRLEN-1:0]   csr_era,
  output logic               int_req,
  output logic               timer_int
);
  logic [2:0] crmd_q, crmd_d, prmd_q, prmd_d;
  logic [12:0] lie_q, lie_d, is_v;
  logic [1:0] is_sw_q, is_sw_d;
  logic [HWI_N-1:0] is_hw_q;
  logic [5:0] ecode_q, ecode_d;
  logic [8:0] esub_q, esub_d;
  logic [GRLEN-1:0] era_q, era_d, badv_q, badv_d, tid_q, tid_d;
  logic [GRLEN-7:0] eentry_q, eentry_d;
  logic [GRLEN-1:0] save_q [NUM_SAVE];
  logic [GRLEN-1:0] save_d [NUM_SAVE];
  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval;
  logic pend, tcfg_we, ticlr;
  function automatic logic hit(input logic [13:0] a);
    return csr_wen && csr_waddr == CSR_BIT'(a);
  endfunction
  function automatic logic [GRLEN-1:0] merge(input logic [GRLEN-1:0] old);
    return (old & ~csr_mask) | (csr_wdata & csr_mask);
  endfunction
  assign tcfg_we = hit(CSR_TCFG);
  assign ticlr = hit(CSR_TICLR) && csr_mask[TICLR_CLR] && csr_wdata[TICLR_CLR];
  // ESTAT.IS assembled from software bits, sampled hardware lines and the timer
  always_comb begin
    is_v = '0;
    is_v[1:0] = is_sw_q;
    is_v[2 +: HWI_N] = is_hw_q;
    is_v[ESTAT_TI] = pend;
  end
  // next state: exception beats ertn beats CSR write
  always_comb begin
    crmd_d = excp_e ? 3'b000 : ertn_e ? prmd_q : hit(CSR_CRMD) ? 3'(merge(GRLEN'(crmd_q))) : crmd_q;
    prmd_d = excp_e ? crmd_q : hit(CSR_PRMD) ? 3'(merge(GRLEN'(prmd_q))) : prmd_q;
    lie_d = hit(CSR_ECFG) ? 13'(merge(GRLEN'(lie_q))) & LIE_MASK : lie_q;
    is_sw_d = hit(CSR_ESTAT) ? 2'(merge(GRLEN'(is_v))) : is_sw_q;
    ecode_d = excp_e ? excp_ecode_e : ecode_q;
    esub_d = excp_e ? excp_esubcode_e : esub_q;
    era_d = excp_e ? pc_e : hit(CSR_ERA) ? merge(era_q) : era_q;
    badv_d = (excp_e && excp_badv_vld_e) ? excp_badv_e : hit(CSR_BADV) ? merge(badv_q) : badv_q;
    eentry_d = hit(CSR_EENTRY) ? (GRLEN-6)'(merge({eentry_q, 6'b0}) >> 6) : eentry_q;
    tid_d = hit(CSR_TID) ? merge(tid_q) : tid_q;
    tcfg_d = tcfg_we ? TIMER_W'(merge(GRLEN'(tcfg_q))) : tcfg_q;
    for (int i = 0; i < NUM_SAVE; i++) save_d[i] = hit(14'(CSR_SAVE_BASE + 14'(i))) ? merge(save_q[i]) : save_q[i];
  end
  // CSR state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q <= '0;
      prmd_q <= '0;
      lie_q <= '0;
      is_sw_q <= '0;
      is_hw_q <= '0;
      ecode_q <= '0;
      esub_q <= '0;
      era_q <= '0;
      badv_q <= '0;
      eentry_q <= '0;
      tid_q <= '0;
      tcfg_q <= '0;
      for (int i = 0; i < NUM_SAVE; i++) save_q[i] <= '0;
    end else begin
      crmd_q <= crmd_d;
      prmd_q <= prmd_d;
      lie_q <= lie_d;
      is_sw_q <= is_sw_d;
      is_hw_q <= hwi;
      ecode_q <= ecode_d;
      esub_q <= esub_d;
      era_q <= era_d;
      badv_q <= badv_d;
      eentry_q <= eentry_d;
      tid_q <= tid_d;
      tcfg_q <= tcfg_d;
      for (int i = 0; i < NUM_SAVE; i++) save_q[i] <= save_d[i];
    end
  end
  cpu7_csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tcfg_we),
    .load_val_i ({tcfg_d[TIMER_W-1:2], 2'b00}),
    .reload_i   ({tcfg_q[TIMER_W-1:2], 2'b00}),
    .en_i       (tcfg_q[TCFG_EN]),
    .periodic_i (tcfg_q[TCFG_PERIODIC]),
    .clr_i      (ticlr),
    .tval_o     (tval),
    .pend_o     (pend)
  );
  // combinational read mux; unimplemented addresses and TICLR read 0
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_BIT'(CSR_CRMD):   csr_rdata = GRLEN'(crmd_q);
      CSR_BIT'(CSR_PRMD):   csr_rdata = GRLEN'(prmd_q);
      CSR_BIT'(CSR_ECFG):   csr_rdata = GRLEN'(lie_q);
      CSR_BIT'(CSR_ESTAT):  csr_rdata = GRLEN'({esub_q, ecode_q, 3'b000, is_v});
      CSR_BIT'(CSR_ERA):    csr_rdata = era_q;
      CSR_BIT'(CSR_BADV):   csr_rdata = badv_q;
      CSR_BIT'(CSR_EENTRY): csr_rdata = {eentry_q, 6'b0};
      CSR_BIT'(CSR_TID):    csr_rdata = tid_q;
      CSR_BIT'(CSR_TCFG):   csr_rdata = GRLEN'(tcfg_q);
      CSR_BIT'(CSR_TVAL):   csr_rdata = GRLEN'(tval);
      default:              csr_rdata = '0;
    endcase
    for (int i = 0; i < NUM_SAVE; i++) if (csr_raddr == CSR_BIT'(CSR_SAVE_BASE + 14'(i))) csr_rdata = save_q[i];
  end
  assign csr_eentry = {eentry_q, 6'b0};
  assign csr_era = era_q;
  assign int_req = |(is_v & lie_q) & crmd_q[CRMD_IE];
  assign timer_int = pend;
endmodule

// File: doc/cpu7_csr_tmr.md
Name: cpu7_csr_tmr

Overview:
- Next-generation CSR file for the cpu7 core. Replaces the fixed CRMD/PRMD/ERA/BADV/EENTRY set with a parametrised one.
- Adds ECFG/ESTAT interrupt bookkeeping, exception codes, NUM_SAVE scratch registers, and a stable-counter timer (TID/TCFG/TVAL/TICLR) with one-shot and periodic modes.
- Sits beside the _e-stage exception logic. Supplies the exception entry, the return address and a registered-state interrupt request to the pipeline.

Parameters:
- GRLEN, 32, datapath and CSR width.
- CSR_BIT, 14, CSR address width.
- NUM_SAVE, 4, number of SAVE scratch CSRs (1..16), at 0x30+i.
- TIMER_W, 32, TVAL counter width (<= GRLEN).
- HWI_N, 8, hardware interrupt lines, mapped to ESTAT.IS[2 +: HWI_N] (HWI_N <= 8).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- csr_raddr  in  CSR_BIT  read address.
- csr_rdata  out  GRLEN  combinational read data; 0 for unimplemented addresses.
- csr_waddr  in  CSR_BIT  write address.
- csr_wdata  in  GRLEN  write data.
- csr_mask  in  GRLEN  per-bit write mask.
- csr_wen  in  1  write strobe.
- excp_e  in  1  exception taken at _e.
- excp_ecode_e  in  6  Ecode.
- excp_esubcode_e  in  9  EsubCode.
- excp_badv_vld_e  in  1  BADV update (ALE, address faults).
- excp_badv_e  in  GRLEN  faulting address.
- pc_e  in  GRLEN  pc of the _e instruction.
- ertn_e  in  1  ertn retiring at _e.
- hwi  in  HWI_N  level hardware interrupts, asynchronous to the pipeline.
- csr_eentry  out  GRLEN  EENTRY value.
- csr_era  out  GRLEN  ERA value.
- int_req  out  1  |(ESTAT.IS & ECFG.LIE) & CRMD.IE.
- timer_int  out  1  ESTAT.IS[11].

Behaviour:
- Reset: every CSR field is 0, so csr_eentry=0, csr_era=0, int_req=0, timer_int=0. TID resets to 0.
- Write rule for writable fields: new = (old & ~csr_mask) | (csr_wdata & csr_mask). Read-only fields ignore writes. All updates land on the clock edge after the strobe; reads see the new value in the next cycle.
- Per-cycle priority: excp_e > ertn_e > CSR write, for every field that more than one of these touches.
- CRMD {IE[2], PLV[1:0]}:
  - excp_e: PRMD <= {IE,PLV}, then IE=0, PLV=0.
  - ertn_e: {IE,PLV} <= PRMD.
- PRMD {PIE[2], PPLV[1:0]}: CSR-writable; loaded only on excp_e.
- ECFG {LIE[12:0]}: bit 10 reserved (reads 0).
- ESTAT:
  - IS[1:0] software-writable.
  - IS[2 +: HWI_N] = hwi registered once per cycle; read-only.
  - IS[11] = timer pending.
  - Ecode[21:16] and EsubCode[30:22] load on excp_e only.
- ERA <= pc_e on excp_e.
- BADV <= excp_badv_e when excp_e & excp_badv_vld_e. Otherwise CSR-writable.
- EENTRY: CSR-writable; bits [5:0] read 0.
- SAVEi: plain GRLEN registers.
- Timer, TCFG {InitVal[TIMER_W-1:2], Periodic[1], En[0]}:
  - A write of TCFG loads TVAL <= {new InitVal, 2'b00}.
  - Each cycle with En=1 and TVAL != 0: TVAL decrements by 1.
  - TVAL transition 1 -> 0: set IS[11]. If Periodic, reload {InitVal,2'b00} in that same cycle instead of holding 0. If not Periodic, hold 0 and stop.
  - InitVal=0 with En=1: never fires.
  - En cleared: TVAL freezes.
  - TVAL is read-only; bits above TIMER_W read 0.
- TICLR: writing bit0=1 (with mask bit0 set) clears IS[11]; TICLR reads 0. If a clear and an expiry fall in the same cycle, the expiry wins and IS[11]=1.
- TID: CSR-writable, no side effects.
- Exceptions do not change TCFG or TVAL.
- Reset asserted mid-count returns everything to 0 on the next edge.

Decomposition:
- Shared constants go in common.vh:
  - CSR addresses: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE_BASE 0x30, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
  - Field bit positions: CRMD_IE, CRMD_PLV, ESTAT_IS, ESTAT_ECODE, ESTAT_ESUBCODE, TCFG_EN, TCFG_PERIODIC, TICLR_CLR.
  - Ecode values.
- One sub-module: cpu7_csr_timer, holding TVAL, the reload logic, and set/clear of the pending bit.

Test Plan:
- Write TCFG=0x0000_0015 (InitVal=5 -> 20, En=1, one-shot) -> TVAL reads 20 the next cycle, reaches 0 20 cycles later. IS[11]=1, timer_int=1; with ECFG.LIE[11]=1 and CRMD.IE=1, int_req=1. TVAL stays 0.
- Same setup with TCFG=0x0000_0017 (periodic) -> IS[11] set every 20 cycles and TVAL reloads to 20 with no dead cycle. TICLR write of 1 clears IS[11]; a TICLR write in the expiry cycle leaves IS[11]=1.
- CRMD=0x7, then excp_e with ecode 0x09, badv_vld, badv 0x1003, pc_e 0x1c00_0040:
  - next cycle: CRMD=0, PRMD=0x7, ERA=0x1c00_0040, BADV=0x1003, ESTAT[21:16]=0x09.
  - ertn_e then restores CRMD=0x7.
- excp_e, ertn_e and a CRMD write with data 0x3 in the same cycle -> exception result (CRMD=0). A CSR write and ertn together -> ertn result.
- hwi[3]=1 with ECFG.LIE[5]=1, CRMD.IE=0 -> ESTAT.IS[5]=1 one cycle later, int_req=0. Setting IE=1 -> int_req=1. SAVE3 write of 0xdeadbeef with mask 0xffff0000 over old 0 -> reads 0xdead0000.
- rst asserted mid-count -> TVAL, TCFG, ESTAT, ERA and EENTRY read 0, and no timer interrupt follows.
